// File: rtl/mux_scan_ctrl_if.sv
// Handshake/bus bundle between the scan controller and its environment.
// The slave side is the controller itself; the master side drives the
// scan requests and the downstream mux output.
interface mux_scan_ctrl_if #(
  parameter int DWELL_W = 4
);
  logic               start;
  logic               stop;
  logic               cont;
  logic [DWELL_W-1:0] dwell;
  logic               mux_out;
  logic [1:0]         sel;
  logic               busy;
  logic [3:0]         frame;
  logic               frame_valid;

  modport slave (
    input  start, stop, cont, dwell, mux_out,
    output sel, busy, frame, frame_valid
  );

  modport master (
    output start, stop, cont, dwell, mux_out,
    input  sel, busy, frame, frame_valid
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scan controller for a downstream 4:1 mux. It steps the registered select
// through channels 0..3, holds each channel for dwell+1 cycles, captures the
// mux output at the end of each dwell into a shadow register, and publishes
// the complete 4-bit frame with a one-cycle frame_valid pulse. Frames are
// single-shot or continuous; stop ends continuous scanning at a frame boundary.
module mux_scan_ctrl #(
  parameter int DWELL_W = 4
) (
  input logic           clk,
  input logic           rst_n,
  mux_scan_ctrl_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t             r_state;
  logic [1:0]         r_sel;
  logic [DWELL_W-1:0] r_cnt;
  logic               r_busy;
  logic [3:0]         r_frame;
  logic               r_frame_valid;
  logic [3:0]         r_shadow;
  logic               r_stop_pending;
  logic [DWELL_W-1:0] r_dwell_q;
  logic               r_cont_q;

  state_t             w_state;
  logic [1:0]         w_sel;
  logic [DWELL_W-1:0] w_cnt;
  logic               w_busy;
  logic [3:0]         w_frame;
  logic               w_frame_valid;
  logic [3:0]         w_shadow;
  logic               w_stop_pending;
  logic [DWELL_W-1:0] w_dwell_q;
  logic               w_cont_q;

  // State register: everything, outputs included, is registered and cleared by async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_sel          <= 2'd0;
      r_cnt          <= '0;
      r_busy         <= 1'b0;
      r_frame        <= 4'b0000;
      r_frame_valid  <= 1'b0;
      r_shadow       <= 4'b0000;
      r_stop_pending <= 1'b0;
      r_dwell_q      <= '0;
      r_cont_q       <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_sel          <= w_sel;
      r_cnt          <= w_cnt;
      r_busy         <= w_busy;
      r_frame        <= w_frame;
      r_frame_valid  <= w_frame_valid;
      r_shadow       <= w_shadow;
      r_stop_pending <= w_stop_pending;
      r_dwell_q      <= w_dwell_q;
      r_cont_q       <= w_cont_q;
    end
  end

  // Next-state logic: dwell counting, per-channel capture and frame hand-off.
  always_comb begin
    w_state        = r_state;
    w_sel          = r_sel;
    w_cnt          = r_cnt;
    w_busy         = r_busy;
    w_frame        = r_frame;
    w_frame_valid  = 1'b0;
    w_shadow       = r_shadow;
    w_stop_pending = r_stop_pending;
    w_dwell_q      = r_dwell_q;
    w_cont_q       = r_cont_q;

    case (r_state)
      IDLE: begin
        w_sel  = 2'd0;
        w_cnt  = '0;
        w_busy = 1'b0;
        if (bus.start) begin
          // stop together with start turns any request into a single frame
          w_state        = SCAN;
          w_busy         = 1'b1;
          w_dwell_q      = bus.dwell;
          w_cont_q       = bus.cont;
          w_stop_pending = bus.stop;
        end else begin
          w_stop_pending = 1'b0;
        end
      end

      SCAN: begin
        // start is ignored here; stop only takes effect at the frame boundary
        if (bus.stop) begin
          w_stop_pending = 1'b1;
        end else begin
          w_stop_pending = r_stop_pending;
        end

        if (r_cnt != r_dwell_q) begin
          w_cnt = r_cnt + DWELL_W'(1);
        end else begin
          w_shadow[r_sel] = bus.mux_out;
          w_cnt           = '0;
          if (r_sel != 2'd3) begin
            w_sel = r_sel + 2'd1;
          end else begin
            // last channel goes straight into frame so it never shows a partial update
            w_frame       = {bus.mux_out, r_shadow[2:0]};
            w_frame_valid = 1'b1;
            w_sel         = 2'd0;
            if (r_cont_q && !r_stop_pending) begin
              w_dwell_q = bus.dwell;
            end else begin
              w_state        = IDLE;
              w_busy         = 1'b0;
              w_stop_pending = 1'b0;
            end
          end
        end
      end

      default: begin
        w_state        = IDLE;
        w_sel          = 2'd0;
        w_cnt          = '0;
        w_busy         = 1'b0;
        w_stop_pending = 1'b0;
      end
    endcase
  end

  assign bus.sel         = r_sel;
  assign bus.busy        = r_busy;
  assign bus.frame       = r_frame;
  assign bus.frame_valid = r_frame_valid;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: a table of single-frame vectors,
// hand-written multi-cycle sequences, and a randomized phase, all checked
// every cycle against a frame-position reference model.
module tb_mux_scan_ctrl;

  localparam int DW = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_pat;

  int total;
  int bad;
  int cyc;

  mux_scan_ctrl_if #(.DWELL_W(DW)) bus ();

  assign bus.mux_out = in_pat[bus.sel];

  mux_scan_ctrl #(.DWELL_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (position within frame) ----------------
  bit       m_busy;
  int       m_pos;
  int       m_d;
  bit       m_cont;
  bit       m_stop;
  bit [3:0] m_cap;
  bit [3:0] m_frame;
  bit       m_fv;

  function automatic void model_reset();
    m_busy  = 1'b0;
    m_pos   = 0;
    m_d     = 0;
    m_cont  = 1'b0;
    m_stop  = 1'b0;
    m_cap   = 4'b0000;
    m_frame = 4'b0000;
    m_fv    = 1'b0;
  endfunction

  // advance the model across one clock edge, using the inputs seen at that edge
  function automatic void model_step();
    int  len;
    int  ch;
    bit  old_stop;
    m_fv = 1'b0;
    if (!m_busy) begin
      if (bus.start) begin
        m_busy = 1'b1;
        m_pos  = 0;
        m_d    = int'(bus.dwell);
        m_cont = bus.cont;
        m_stop = bus.stop;
      end
    end else begin
      len      = m_d + 1;
      ch       = m_pos / len;
      old_stop = m_stop;
      if (bus.stop) m_stop = 1'b1;
      if ((m_pos % len) == m_d) m_cap[ch] = in_pat[ch];
      if (m_pos == 4 * len - 1) begin
        m_frame = m_cap;
        m_fv    = 1'b1;
        if (m_cont && !old_stop) begin
          m_pos = 0;
          m_d   = int'(bus.dwell);
        end else begin
          m_busy = 1'b0;
          m_stop = 1'b0;
        end
      end else begin
        m_pos = m_pos + 1;
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic check_model();
    logic [1:0] esel;
    esel = m_busy ? 2'(m_pos / (m_d + 1)) : 2'd0;
    chk("sel_busy_frame_fv",
        {24'd0, bus.sel, bus.busy, bus.frame, bus.frame_valid},
        {24'd0, esel, m_busy, m_frame, m_fv});
  endtask

  // one clock: model sees current inputs, DUT samples them, compare #1 after the edge
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check_model();
  endtask

  task automatic wait_fv(input int bound, output int at_cyc);
    int n;
    n      = 0;
    at_cyc = -1;
    while (!bus.frame_valid && n < bound) begin
      step();
      n++;
    end
    if (bus.frame_valid) begin
      at_cyc = cyc;
    end else begin
      chk("frame_valid_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic start_frame(input logic c, input logic s, input int d, input logic [3:0] pat,
                             output int t0);
    bus.cont   = c;
    bus.stop   = s;
    bus.dwell  = DW'(d);
    in_pat     = pat;
    bus.start  = 1'b1;
    step();
    t0         = cyc;
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
  endtask

  typedef struct {
    logic       cont;
    int         dwell;
    logic [3:0] pat;
    logic [3:0] exp_frame;
    int         exp_lat;
  } vec_t;

  vec_t vt[5];

  initial begin
    int t0;
    int t1;
    int t2;

    total     = 0;
    bad       = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    in_pat    = 4'b0000;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.cont  = 1'b0;
    bus.dwell = '0;
    model_reset();

    vt[0] = '{1'b0, 0,  4'b1010, 4'b1010, 4};
    vt[1] = '{1'b0, 3,  4'b0110, 4'b0110, 16};
    vt[2] = '{1'b0, 15, 4'b1001, 4'b1001, 64};
    vt[3] = '{1'b0, 1,  4'b1111, 4'b1111, 8};
    vt[4] = '{1'b0, 2,  4'b0000, 4'b0000, 12};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {24'd0, bus.sel, bus.busy, bus.frame, bus.frame_valid}, 32'd0);
    rst_n = 1'b1;
    step();

    // table-driven single frames
    for (int i = 0; i < 5; i++) begin
      start_frame(vt[i].cont, 1'b0, vt[i].dwell, vt[i].pat, t0);
      wait_fv(200, t1);
      chk("single_latency", 32'(t1 - t0), 32'(vt[i].exp_lat));
      chk("single_frame", {28'd0, bus.frame}, {28'd0, vt[i].exp_frame});
      chk("single_busy_end", {31'd0, bus.busy}, 32'd0);
      step();
      chk("single_fv_one_cycle", {31'd0, bus.frame_valid}, 32'd0);
      chk("single_frame_hold", {28'd0, bus.frame}, {28'd0, vt[i].exp_frame});
    end

    // continuous: two frames, stop during the second
    start_frame(1'b1, 1'b0, 1, 4'b0001, t0);
    wait_fv(200, t1);
    chk("cont_frame1", {28'd0, bus.frame}, 32'h1);
    chk("cont_busy_mid", {31'd0, bus.busy}, 32'd1);
    in_pat = 4'b1000;
    repeat (3) step();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    wait_fv(200, t2);
    chk("cont_spacing", 32'(t2 - t1), 32'd8);
    chk("cont_frame2", {28'd0, bus.frame}, 32'h8);
    chk("cont_stop_idle", {31'd0, bus.busy}, 32'd0);

    // ignored start and dwell change while busy
    start_frame(1'b0, 1'b0, 2, 4'b1100, t0);
    repeat (3) step();
    bus.start = 1'b1;
    bus.dwell = DW'(7);
    step();
    bus.start = 1'b0;
    wait_fv(200, t1);
    chk("ignore_latency", 32'(t1 - t0), 32'd12);
    chk("ignore_frame", {28'd0, bus.frame}, 32'hC);

    // stop in IDLE does nothing
    bus.stop = 1'b1;
    repeat (3) step();
    bus.stop = 1'b0;
    chk("idle_stop_busy", {31'd0, bus.busy}, 32'd0);
    chk("idle_stop_frame", {28'd0, bus.frame}, 32'hC);

    // start+stop together with cont=1 gives exactly one frame
    start_frame(1'b1, 1'b1, 0, 4'b0101, t0);
    wait_fv(200, t1);
    chk("startstop_latency", 32'(t1 - t0), 32'd4);
    chk("startstop_frame", {28'd0, bus.frame}, 32'h5);
    chk("startstop_idle", {31'd0, bus.busy}, 32'd0);
    repeat (6) step();
    chk("startstop_still_idle", {31'd0, bus.busy}, 32'd0);

    // async reset in the middle of channel 2
    start_frame(1'b0, 1'b0, 3, 4'b1111, t0);
    repeat (9) step();
    chk("pre_reset_sel", {30'd0, bus.sel}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {24'd0, bus.sel, bus.busy, bus.frame, bus.frame_valid}, 32'd0);
    rst_n = 1'b1;
    model_reset();
    repeat (20) step();
    start_frame(1'b0, 1'b0, 0, 4'b0011, t0);
    wait_fv(200, t1);
    chk("post_reset_latency", 32'(t1 - t0), 32'd4);
    chk("post_reset_frame", {28'd0, bus.frame}, 32'h3);

    // randomized phase against the model
    for (int r = 0; r < 600; r++) begin
      bus.start = ($urandom_range(0, 7) == 0);
      bus.stop  = ($urandom_range(0, 15) == 0);
      bus.cont  = 1'($urandom_range(0, 1));
      bus.dwell = DW'($urandom_range(0, 3));
      in_pat    = 4'($urandom_range(0, 15));
      step();
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 The block SHALL have parameter DWELL_W, default 4, giving the width of the per-channel dwell count.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, a request to begin a scan frame, sampled at the clock edge.
REQ-005 The block SHALL have port stop, input, 1, a request to end continuous scanning after the current frame.
REQ-006 The block SHALL have port cont, input, 1; 1 selects continuous frames and 0 selects a single frame; sampled with start.
REQ-007 The block SHALL have port dwell, input, DWELL_W, giving cycles per channel minus one.
REQ-008 The block SHALL have port mux_out, input, 1, the output of the downstream 4:1 mux.
REQ-009 The block SHALL have port sel, output, 2, the registered select driving the downstream 4:1 mux.
REQ-010 The block SHALL have port busy, output, 1, which is high while a scan is in progress.
REQ-011 The block SHALL have port frame, output, 4, holding the captured sample of channel i in bit i.
REQ-012 The block SHALL have port frame_valid, output, 1, a one-cycle pulse marking an update of frame.

Function
REQ-013 The FSM SHALL have two states, IDLE and SCAN.
REQ-014 In IDLE, busy, sel and the dwell counter cnt SHALL all be 0.
REQ-015 In IDLE, start=1 SHALL cause the following on the next edge: go to SCAN, busy=1, sel=0, cnt=0, latch dwell into dwell_q, and latch cont into cont_q.
REQ-016 In SCAN, cnt SHALL increment each cycle while cnt != dwell_q.
REQ-017 On the edge where cnt == dwell_q, mux_out SHALL be captured into shadow bit [sel].
REQ-018 On that edge, if sel < 3, sel SHALL increment and cnt SHALL return to 0.
REQ-019 On the capture edge of sel == 3, frame SHALL load {mux_out, shadow[2:0]} and frame_valid SHALL go to 1 on the same edge, for exactly one cycle.
REQ-020 After the sel == 3 capture, if cont_q=1 and stop_pending=0, the block SHALL stay in SCAN, set sel=0 and cnt=0, and re-latch dwell into dwell_q.
REQ-021 After the sel == 3 capture, in all other cases the block SHALL go to IDLE with busy=0, sel=0 and stop_pending=0.
REQ-022 Latency: with start sampled at edge k, frame_valid SHALL be high in the cycle following edge k+4*(dwell+1).
REQ-023 Each channel SHALL be presented on sel for exactly dwell+1 cycles.
REQ-024 dwell=0 SHALL give one cycle per channel and a 4-cycle frame.
REQ-025 dwell at its maximum value SHALL give 2^DWELL_W cycles per channel with no counter wrap.
REQ-026 Changes to dwell during a frame SHALL be ignored until the next frame boundary.
REQ-027 start while busy SHALL be ignored; no restart and no effect on sel or cnt.
REQ-028 stop in SCAN SHALL set stop_pending; the current frame always completes and frame_valid is still produced.
REQ-029 stop in IDLE SHALL be ignored.
REQ-030 start and stop together in IDLE SHALL start a single frame by setting stop_pending=1, regardless of cont.
REQ-031 frame SHALL hold its value between frame_valid pulses.
REQ-032 frame SHALL never show a partial frame.

Reset
REQ-033 rst_n=0 SHALL immediately force the following, independent of clk: state IDLE, sel=0, cnt=0, busy=0, frame=4'b0000, frame_valid=0, shadow=0, stop_pending=0, dwell_q=0, cont_q=0.
REQ-034 Reset mid-frame SHALL abandon the frame with no frame_valid pulse.
REQ-035 After rst_n returns high, the block SHALL stay in IDLE until start is sampled.

Verification
REQ-036 Single frame, dwell=0: cont=0, start pulse, mux input in=4'b1010 -> sel steps 0,1,2,3 one cycle each; frame=4'b1010 with one frame_valid pulse 4 cycles after start; busy=0 afterwards.
REQ-037 Dwell, dwell=3: in=4'b0110 -> each sel value held 4 cycles; frame_valid 16 cycles after start; frame=4'b0110.
REQ-038 Continuous mode: cont=1, in changed between frames from 4'b0001 to 4'b1000 -> consecutive frames 0001 then 1000; frame_valid pulses 4*(dwell+1) apart; assert stop mid-frame -> that frame completes, then IDLE.
REQ-039 Ignored inputs: start while busy, and dwell changed mid-frame -> frame timing unchanged; stop in IDLE -> no state change.
REQ-040 Simultaneous start and stop in IDLE with cont=1 -> exactly one frame, then IDLE.
REQ-041 Asynchronous reset at the sel=2 dwell midpoint -> all outputs 0 immediately with no clock edge; no frame_valid; a new start gives normal timing.
